// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and state encoding for the pipeline sequencer
package pipe_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;

  typedef enum logic [1:0] {
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_TRAP  = ST_TRAP
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hold_watchdog.sv
// rtl/pipe_ctrl_hold_watchdog.sv - bus stall watchdog: counts consecutive stall cycles, pulses once on timeout
//
// Ports:
//   clk_i   clock, rising edge
//   rstn_i  asynchronous active-low reset
//   hold_i  bus stall request
//   err_o   1-cycle pulse on the stall cycle that brings the count to TIMEOUT
module pipe_ctrl_hold_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic hold_i,
  output logic err_o
);

  localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Counter saturates at TIMEOUT, so the pre-terminal value is seen only once per stall.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_o = hold_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer: hold merge, jump/trap redirect, flush and trap entry
//
// Ports:
//   clk_i, rstn_i                   clock / asynchronous active-low reset
//   exPC_i                          PC of the instruction in EX
//   exJumpEn_i, exJumpAddr_i        EX taken branch/jump and target
//   exHoldReq_i, busHoldReq_i       EX multi-cycle busy, bus stall
//   clintReq_i, clintAddr_i         trap request (level) and vector
//   clintAck_o, trapRetPC_o         trap taken pulse and return PC
//   pcJumpEn_o, pcJumpAddr_o        PC register jump redirect
//   pcTrapEn_o, pcTrapAddr_o        PC register trap redirect
//   holdFlag_o                      freeze PC and pipeline registers
//   flushIF_o, flushID_o            clear IF/ID and ID/EX registers
//   busErr_o                        bus timeout pulse
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int BUS_TIMEOUT  = 255
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [XLEN-1:0] exPC_i,
  input  logic            exJumpEn_i,
  input  logic [XLEN-1:0] exJumpAddr_i,
  input  logic            exHoldReq_i,
  input  logic            busHoldReq_i,
  input  logic            clintReq_i,
  input  logic [XLEN-1:0] clintAddr_i,
  output logic            clintAck_o,
  output logic [XLEN-1:0] trapRetPC_o,
  output logic            pcJumpEn_o,
  output logic [XLEN-1:0] pcJumpAddr_o,
  output logic            pcTrapEn_o,
  output logic [XLEN-1:0] pcTrapAddr_o,
  output logic            holdFlag_o,
  output logic            flushIF_o,
  output logic            flushID_o,
  output logic            busErr_o
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;
  logic [XLEN-1:0]   last_tgt_q, last_tgt_d;
  logic              redir_q;

  logic              jump_en, trap_en, hold, redirect, bus_err;

  always_comb begin
    state_d = state_q;
    jump_en = exJumpEn_i;
    trap_en = 1'b0;
    hold    = exHoldReq_i | busHoldReq_i;
    unique case (state_q)
      S_RUN: begin
        // A jump in the same cycle is taken now; the trap follows next cycle.
        if (clintReq_i) begin
          state_d = exHoldReq_i ? S_DRAIN : S_TRAP;
        end
      end
      S_DRAIN: begin
        hold = 1'b1;
        if (!clintReq_i) begin
          state_d = S_RUN;
        end else if (!exHoldReq_i) begin
          state_d = S_TRAP;
        end
      end
      S_TRAP: begin
        // Trap owns the redirect: the EX jump is dropped and nothing is held.
        jump_en = 1'b0;
        trap_en = 1'b1;
        hold    = 1'b0;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  assign redirect = jump_en | trap_en;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    last_tgt_d  = last_tgt_q;
    if (redirect) begin
      flush_cnt_d = FLUSH_RELOAD;
      last_tgt_d  = trap_en ? clintAddr_i : exJumpAddr_i;
    end else if (flush_cnt_q != 2'd0 && !hold) begin
      flush_cnt_d = flush_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
      last_tgt_q  <= '0;
      redir_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      last_tgt_q  <= last_tgt_d;
      redir_q     <= redirect;
    end
  end

  pipe_ctrl_hold_watchdog #(
    .TIMEOUT (BUS_TIMEOUT)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .hold_i (busHoldReq_i),
    .err_o  (bus_err)
  );

  // Combinational paths are gated by reset so every output reads 0 while rstn_i is low.
  always_comb begin
    pcJumpEn_o   = rstn_i & jump_en;
    pcJumpAddr_o = rstn_i ? exJumpAddr_i : '0;
    pcTrapEn_o   = rstn_i & trap_en;
    pcTrapAddr_o = (rstn_i && trap_en) ? clintAddr_i : '0;
    clintAck_o   = rstn_i & trap_en;
    // A redirect last cycle means exPC is stale; the real next PC is the last target.
    trapRetPC_o  = (rstn_i && trap_en) ? (redir_q ? last_tgt_q : exPC_i) : '0;
    holdFlag_o   = rstn_i & hold;
    flushIF_o    = rstn_i & (redirect | (flush_cnt_q != 2'd0));
    flushID_o    = flushIF_o;
    busErr_o     = rstn_i & bus_err;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed table-driven bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk;
  logic        rstn;
  logic [31:0] exPC, exJumpAddr, clintAddr;
  logic        exJumpEn, exHoldReq, busHoldReq, clintReq;
  logic        clintAck, pcJumpEn, pcTrapEn, holdFlag, flushIF, flushID, busErr;
  logic [31:0] trapRetPC, pcJumpAddr, pcTrapAddr;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_ctrl #(.FLUSH_CYCLES(2), .BUS_TIMEOUT(255)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .exPC_i       (exPC),
    .exJumpEn_i   (exJumpEn),
    .exJumpAddr_i (exJumpAddr),
    .exHoldReq_i  (exHoldReq),
    .busHoldReq_i (busHoldReq),
    .clintReq_i   (clintReq),
    .clintAddr_i  (clintAddr),
    .clintAck_o   (clintAck),
    .trapRetPC_o  (trapRetPC),
    .pcJumpEn_o   (pcJumpEn),
    .pcJumpAddr_o (pcJumpAddr),
    .pcTrapEn_o   (pcTrapEn),
    .pcTrapAddr_o (pcTrapAddr),
    .holdFlag_o   (holdFlag),
    .flushIF_o    (flushIF),
    .flushID_o    (flushID),
    .busErr_o     (busErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        jmp;
    logic [31:0] jaddr;
    logic        exh;
    logic        bush;
    logic        clr;
    logic [31:0] pc;
    logic        e_jen;
    logic        e_ten;
    logic        e_ack;
    logic [31:0] e_ret;
    logic        e_hold;
    logic        e_flush;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic jmp, input logic [31:0] ja, input logic exh,
                              input logic bush, input logic clr, input logic [31:0] pc,
                              input logic ejen, input logic eten, input logic eack,
                              input logic [31:0] eret, input logic ehold, input logic eflush);
    vec_t v;
    v.jmp = jmp; v.jaddr = ja; v.exh = exh; v.bush = bush; v.clr = clr; v.pc = pc;
    v.e_jen = ejen; v.e_ten = eten; v.e_ack = eack; v.e_ret = eret;
    v.e_hold = ehold; v.e_flush = eflush;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic jmp, input logic [31:0] ja, input logic exh,
                       input logic bush, input logic clr, input logic [31:0] pc);
    exJumpEn   = jmp;
    exJumpAddr = ja;
    exHoldReq  = exh;
    busHoldReq = bush;
    clintReq   = clr;
    clintAddr  = clr ? 32'h80 : 32'h0;
    exPC       = pc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pcJumpEn"},   {31'd0, pcJumpEn},  32'd0);
    chk({tag, ".pcJumpAddr"}, pcJumpAddr,         32'd0);
    chk({tag, ".pcTrapEn"},   {31'd0, pcTrapEn},  32'd0);
    chk({tag, ".pcTrapAddr"}, pcTrapAddr,         32'd0);
    chk({tag, ".clintAck"},   {31'd0, clintAck},  32'd0);
    chk({tag, ".trapRetPC"},  trapRetPC,          32'd0);
    chk({tag, ".holdFlag"},   {31'd0, holdFlag},  32'd0);
    chk({tag, ".flushIF"},    {31'd0, flushIF},   32'd0);
    chk({tag, ".flushID"},    {31'd0, flushID},   32'd0);
    chk({tag, ".busErr"},     {31'd0, busErr},    32'd0);
  endtask

  initial begin
    int pulses;
    int pulse_idx;
    int hold_bad;
    string tag;

    rstn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #3;
    chk_all_zero("reset0");
    @(posedge clk); @(posedge clk);
    #1 rstn = 1'b1;

    // jump, DRAIN trap, jump+trap, dropped request, flush under hold, jump in DRAIN
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h10,  0,0,0, 32'h0,   0,0));
    vecs.push_back(mk(1, 32'h100, 0,0,0, 32'h14,  1,0,0, 32'h0,   0,1));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h100, 0,0,0, 32'h0,   0,1));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h104, 0,0,0, 32'h0,   0,0));
    vecs.push_back(mk(0, 32'h0,   1,0,1, 32'h40,  0,0,0, 32'h0,   1,0));
    vecs.push_back(mk(0, 32'h0,   1,0,1, 32'h40,  0,0,0, 32'h0,   1,0));
    vecs.push_back(mk(0, 32'h0,   1,0,1, 32'h40,  0,0,0, 32'h0,   1,0));
    vecs.push_back(mk(0, 32'h0,   0,0,1, 32'h44,  0,0,0, 32'h0,   1,0));
    vecs.push_back(mk(1, 32'h300, 0,0,1, 32'h44,  0,1,1, 32'h44,  0,1));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h80,  0,0,0, 32'h0,   0,1));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h84,  0,0,0, 32'h0,   0,0));
    vecs.push_back(mk(1, 32'h200, 0,0,1, 32'h50,  1,0,0, 32'h0,   0,1));
    vecs.push_back(mk(0, 32'h0,   0,0,1, 32'h54,  0,1,1, 32'h200, 0,1));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h80,  0,0,0, 32'h0,   0,1));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h84,  0,0,0, 32'h0,   0,0));
    vecs.push_back(mk(0, 32'h0,   1,0,1, 32'h60,  0,0,0, 32'h0,   1,0));
    vecs.push_back(mk(0, 32'h0,   1,0,1, 32'h60,  0,0,0, 32'h0,   1,0));
    vecs.push_back(mk(0, 32'h0,   1,0,0, 32'h60,  0,0,0, 32'h0,   1,0));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h64,  0,0,0, 32'h0,   0,0));
    vecs.push_back(mk(1, 32'h400, 0,1,0, 32'h68,  1,0,0, 32'h0,   1,1));
    vecs.push_back(mk(0, 32'h0,   0,1,0, 32'h400, 0,0,0, 32'h0,   1,1));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h400, 0,0,0, 32'h0,   0,1));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h404, 0,0,0, 32'h0,   0,0));
    vecs.push_back(mk(0, 32'h0,   1,0,1, 32'h70,  0,0,0, 32'h0,   1,0));
    vecs.push_back(mk(1, 32'h500, 0,0,1, 32'h74,  1,0,0, 32'h0,   1,1));
    vecs.push_back(mk(0, 32'h0,   0,0,1, 32'h78,  0,1,1, 32'h500, 0,1));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h80,  0,0,0, 32'h0,   0,1));
    vecs.push_back(mk(0, 32'h0,   0,0,0, 32'h84,  0,0,0, 32'h0,   0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 drive(vecs[i].jmp, vecs[i].jaddr, vecs[i].exh, vecs[i].bush, vecs[i].clr, vecs[i].pc);
      #3;
      tag = $sformatf("v%0d", i);
      chk({tag, ".pcJumpEn"},   {31'd0, pcJumpEn}, {31'd0, vecs[i].e_jen});
      chk({tag, ".pcJumpAddr"}, pcJumpAddr,        vecs[i].jaddr);
      chk({tag, ".pcTrapEn"},   {31'd0, pcTrapEn}, {31'd0, vecs[i].e_ten});
      chk({tag, ".pcTrapAddr"}, pcTrapAddr,        vecs[i].e_ten ? 32'h80 : 32'h0);
      chk({tag, ".clintAck"},   {31'd0, clintAck}, {31'd0, vecs[i].e_ack});
      chk({tag, ".trapRetPC"},  trapRetPC,         vecs[i].e_ret);
      chk({tag, ".holdFlag"},   {31'd0, holdFlag}, {31'd0, vecs[i].e_hold});
      chk({tag, ".flushIF"},    {31'd0, flushIF},  {31'd0, vecs[i].e_flush});
      chk({tag, ".flushID"},    {31'd0, flushID},  {31'd0, vecs[i].e_flush});
      chk({tag, ".busErr"},     {31'd0, busErr},   32'd0);
    end

    // Reset asserted mid-DRAIN with active inputs
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h90);
    @(posedge clk);
    #1 drive(1'b1, 32'h600, 1'b1, 1'b1, 1'b1, 32'h90);
    #1 rstn = 1'b0;
    #2 chk_all_zero("rst_mid");
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h94);
    #3 chk_all_zero("rst_hold");
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #4;
      chk($sformatf("rst_rel%0d.flushIF", i), {31'd0, flushIF},  32'd0);
      chk($sformatf("rst_rel%0d.clintAck", i), {31'd0, clintAck}, 32'd0);
    end
    // FSM back in RUN: a plain request traps on the following cycle
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA0);
    #3 chk("rst_run.ack0", {31'd0, clintAck}, 32'd0);
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA4);
    #3;
    chk("rst_run.ack1", {31'd0, clintAck}, 32'd1);
    chk("rst_run.ret",  trapRetPC,         32'hA4);
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h80);
    @(posedge clk);
    @(posedge clk);

    // Bus watchdog: 260 consecutive stall cycles
    pulses = 0; pulse_idx = 0; hold_bad = 0;
    for (int i = 1; i <= 260; i++) begin
      @(posedge clk);
      #1 drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h80);
      #3;
      if (busErr) begin
        pulses++;
        pulse_idx = i;
      end
      if (!holdFlag) hold_bad++;
    end
    chk("wd.pulses",   pulses,    32'd1);
    chk("wd.pulseidx", pulse_idx, 32'd255);
    chk("wd.holdbad",  hold_bad,  32'd0);
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h80);
    #3;
    chk("wd.drop.busErr",   {31'd0, busErr},   32'd0);
    chk("wd.drop.holdFlag", {31'd0, holdFlag}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
